svn_scan_ctrl: RTL

SVN_SCAN_CTRL -- requirements
Module: svn_scan_ctrl

---
 rtl/svn_pkg.sv | 28 ++
 rtl/svn_tick_gen.sv | 30 +++
 rtl/svn_scan_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/svn_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scanner.
//   NUM_DIGITS : digits per frame
//   NIB_W      : bits per displayed digit (one hex nibble)
//   AN_OFF     : anode pattern with every digit dark (anodes are active-low)
//   lz_blank() : per-digit leading-zero blanking mask for a displayed value
package svn_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int NIB_W      = 4;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 8'hFF;

    // Digit k is blanked when enabled, k>0, and nibbles k..7 are all zero.
    // Walk from the top nibble down, keeping a running "everything above is
    // zero" flag. Digit 0 is never blanked, so a zero value still shows "0".
    function automatic logic [NUM_DIGITS-1:0] lz_blank(
        input logic [NUM_DIGITS*NIB_W-1:0] val,
        input logic                        en
    );
        logic upper_zero;
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            upper_zero  = upper_zero && (val[k*NIB_W +: NIB_W] == '0);
            lz_blank[k] = en && upper_zero;
        end
    endfunction

endpackage

// File: rtl/svn_tick_gen.sv
// Slot prescaler: counts 0..CLK_DIV-1 and wraps.
//   clk       : system clock, rising edge
//   sys_rst_n : synchronous active-low reset (count returns to 0)
//   tick      : high during the last cycle of each slot (count == CLK_DIV-1)
module svn_tick_gen #(
    parameter int CLK_DIV = 100000
) (
    input  logic clk,
    input  logic sys_rst_n,
    output logic tick
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] pre_cnt;

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            pre_cnt <= '0;
        end else if (pre_cnt == LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    assign tick = (pre_cnt == LAST);

endmodule

// File: rtl/svn_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller.
//   clk, sys_rst_n : system clock, synchronous active-low reset
//   val_in/val_load: value to show and its capture strobe; the captured value
//                    is committed to the display only at a frame boundary
//   dp_mask, lz_en : per-digit decimal points, leading-zero blanking enable
//   digit, dp_n, AN: registered nibble / active-low dp / active-low anodes
//   busy           : a loaded value is waiting for the next frame boundary
//   frame_done     : high for the single cycle where the scan wraps 7 -> 0
module svn_scan_ctrl
    import svn_pkg::*;
#(
    parameter int CLK_DIV   = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic                        clk,
    input  logic                        sys_rst_n,
    input  logic [NUM_DIGITS*NIB_W-1:0] val_in,
    input  logic                        val_load,
    input  logic [NUM_DIGITS-1:0]       dp_mask,
    input  logic                        lz_en,
    output logic [NIB_W-1:0]            digit,
    output logic                        dp_n,
    output logic [NUM_DIGITS-1:0]       AN,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = $clog2(BLANK_CYC + 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic                        tick;
    logic [IW-1:0]               idx;
    logic [BW-1:0]               blank_cnt;
    logic [NUM_DIGITS*NIB_W-1:0] pend_reg;
    logic [NUM_DIGITS*NIB_W-1:0] disp_reg;
    logic [NUM_DIGITS-1:0]       blank_mask;
    logic                        in_blank;

    svn_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .tick      (tick)
    );

    // Tracks min(pre_cnt, BLANK_CYC): cleared in step with the prescaler wrap,
    // so in_blank is exactly pre_cnt < BLANK_CYC without exporting pre_cnt.
    always_ff @(posedge clk) begin
        if (!sys_rst_n || tick) begin
            blank_cnt <= '0;
        end else if (blank_cnt < BW'(BLANK_CYC)) begin
            blank_cnt <= blank_cnt + 1'b1;
        end
    end

    assign in_blank = (blank_cnt < BW'(BLANK_CYC));

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            idx <= '0;
        end else if (tick) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    assign frame_done = tick && (idx == IDX_LAST);

    // Double-buffered value: loads land in pend_reg, and disp_reg only moves
    // on the frame wrap so a frame never mixes old and new digits. A load on
    // the wrap cycle itself bypasses the pending stage.
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            pend_reg <= '0;
            disp_reg <= '0;
            busy     <= 1'b0;
        end else begin
            if (val_load) begin
                pend_reg <= val_in;
            end
            if (frame_done) begin
                if (val_load) begin
                    disp_reg <= val_in;
                end else if (busy) begin
                    disp_reg <= pend_reg;
                end
                busy <= 1'b0;
            end else if (val_load) begin
                busy <= 1'b1;
            end
        end
    end

    assign blank_mask = lz_blank(disp_reg, lz_en);

    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            AN    <= AN_OFF;
            digit <= '0;
            dp_n  <= 1'b1;
        end else begin
            AN    <= (in_blank || blank_mask[idx]) ? AN_OFF
                                                   : ~(NUM_DIGITS'(1) << idx);
            digit <= disp_reg[idx*NIB_W +: NIB_W];
            dp_n  <= ~dp_mask[idx];
        end
    end

endmodule
